// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, load funct3 codes and load extension helper for the writeback arbiter
package wb_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Consecutive starved-load grants tolerated before the ALU head is forced through.
    localparam logic [1:0] STARVE_MAX = 2'd3;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_LOAD = 2'd1,
        GNT_ALU  = 2'd2
    } gnt_e;

    typedef struct packed {
        logic [REG_AW-1:0] waddr;
        logic [XLEN-1:0]   wdata;
    } wb_ent_t;

    function automatic logic [XLEN-1:0] load_extend(
        input logic [2:0]      funct3,
        input logic [1:0]      addr_lo,
        input logic [XLEN-1:0] rdata
    );
        logic [XLEN-1:0] sh;
        sh = rdata >> {addr_lo, 3'b000};
        case (funct3)
            F3_LB:   load_extend = {{24{sh[7]}}, sh[7:0]};
            F3_LH:   load_extend = {{16{sh[15]}}, sh[15:0]};
            F3_LBU:  load_extend = {24'd0, sh[7:0]};
            F3_LHU:  load_extend = {16'd0, sh[15:0]};
            default: load_extend = rdata;
        endcase
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - power-of-two deep FIFO with simultaneous push/pop and first-word-fall-through head
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_tvalid,
    output logic             in_tready,
    input  logic [WIDTH-1:0] in_tdata,
    output logic             out_tvalid,
    input  logic             out_tready,
    output logic [WIDTH-1:0] out_tdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    assign in_tready  = (count != CW'(DEPTH));
    assign out_tvalid = (count != '0);
    assign out_tdata  = mem[rd_ptr];
    assign push       = in_tvalid & in_tready;
    assign pop        = out_tvalid & out_tready;

    // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_tdata;
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - merges ALU results and load words onto one register write port (WB_LOAD_EXT_EN enables load extension)
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int ALU_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [REG_AW-1:0] ex_waddr_i,
    input  logic [XLEN-1:0]   ex_wdata_i,
    input  logic              mem_valid_i,
    output logic              mem_ready_o,
    input  logic [REG_AW-1:0] mem_waddr_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    input  logic [2:0]        mem_funct3_i,
    input  logic [1:0]        mem_addr_lo_i,
    output logic              reg_wen_o,
    output logic [REG_AW-1:0] reg_waddr_o,
    output logic [XLEN-1:0]   reg_wdata_o,
    output logic              busy_o
);

    wb_ent_t    ex_ent;
    wb_ent_t    load_in;
    wb_ent_t    fifo_head;
    wb_ent_t    hold_q;
    wb_ent_t    load_ent;
    wb_ent_t    alu_ent;
    wb_ent_t    win;
    logic       hold_valid_q;
    logic [1:0] starve_q;
    logic       fifo_in_ready;
    logic       fifo_head_valid;
    logic       fifo_push;
    logic       fifo_pop;
    logic       ex_fire;
    logic       mem_fire;
    logic       load_cand;
    logic       alu_cand;
    logic       wr_en;
    gnt_e       gnt;

    assign ex_ready_o  = ~rst & fifo_in_ready;
    assign mem_ready_o = ~rst & ~hold_valid_q;
    assign ex_fire     = ex_valid_i & ex_ready_o;
    assign mem_fire    = mem_valid_i & mem_ready_o;
    assign ex_ent      = '{waddr: ex_waddr_i, wdata: ex_wdata_i};

`ifdef WB_LOAD_EXT_EN
    assign load_in = '{waddr: mem_waddr_i,
                       wdata: load_extend(mem_funct3_i, mem_addr_lo_i, mem_rdata_i)};
`else
    logic unused_load_ctrl;
    assign unused_load_ctrl = ^{mem_funct3_i, mem_addr_lo_i};
    assign load_in = '{waddr: mem_waddr_i, wdata: mem_rdata_i};
`endif

    wb_fifo #(
        .DEPTH(ALU_DEPTH),
        .WIDTH(REG_AW + XLEN)
    ) u_alu_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_tvalid (fifo_push),
        .in_tready (fifo_in_ready),
        .in_tdata  (ex_ent),
        .out_tvalid(fifo_head_valid),
        .out_tready(fifo_pop),
        .out_tdata (fifo_head)
    );

    // Arrivals compete in the same cycle they are accepted, giving latency 1 when uncontended.
    always_comb begin
        gnt       = GNT_NONE;
        win       = '0;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        load_cand = hold_valid_q | mem_fire;
        alu_cand  = fifo_head_valid | ex_fire;
        load_ent  = hold_valid_q ? hold_q : load_in;
        alu_ent   = fifo_head_valid ? fifo_head : ex_ent;

        if (alu_cand && (!load_cand || (starve_q == STARVE_MAX && fifo_head_valid))) begin
            gnt = GNT_ALU;
        end else if (load_cand) begin
            gnt = GNT_LOAD;
        end

        case (gnt)
            GNT_ALU:  win = alu_ent;
            GNT_LOAD: win = load_ent;
            default:  win = '0;
        endcase

        fifo_pop  = (gnt == GNT_ALU) && fifo_head_valid;
        fifo_push = ex_fire && !((gnt == GNT_ALU) && !fifo_head_valid);
    end

    assign wr_en = (gnt != GNT_NONE) && (win.waddr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
            starve_q     <= '0;
            reg_wen_o    <= 1'b0;
            reg_waddr_o  <= '0;
            reg_wdata_o  <= '0;
        end else begin
            if (!hold_valid_q) begin
                hold_valid_q <= mem_fire && (gnt != GNT_LOAD);
                hold_q       <= load_in;
            end else if (gnt == GNT_LOAD) begin
                hold_valid_q <= 1'b0;
            end

            // Only loads granted past an already-queued ALU result count as starvation.
            case (gnt)
                GNT_ALU:  starve_q <= '0;
                GNT_LOAD: starve_q <= !fifo_head_valid ? 2'd0 :
                                      (starve_q == STARVE_MAX) ? STARVE_MAX : starve_q + 2'd1;
                default:  starve_q <= starve_q;
            endcase

            reg_wen_o   <= wr_en;
            reg_waddr_o <= wr_en ? win.waddr : '0;
            reg_wdata_o <= wr_en ? win.wdata : '0;
        end
    end

    assign busy_o = fifo_head_valid | hold_valid_q | reg_wen_o;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter: vector table, corner sequences, randomized model compare
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_rdata;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_addr_lo;
    logic        reg_wen;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.ALU_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid_i   (ex_valid),
        .ex_ready_o   (ex_ready),
        .ex_waddr_i   (ex_waddr),
        .ex_wdata_i   (ex_wdata),
        .mem_valid_i  (mem_valid),
        .mem_ready_o  (mem_ready),
        .mem_waddr_i  (mem_waddr),
        .mem_rdata_i  (mem_rdata),
        .mem_funct3_i (mem_funct3),
        .mem_addr_lo_i(mem_addr_lo),
        .reg_wen_o    (reg_wen),
        .reg_waddr_o  (reg_waddr),
        .reg_wdata_o  (reg_wdata),
        .busy_o       (busy)
    );

    // Reference model: pending results as queues, write decided per the arbitration rules.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        alu_q[$];
    ent_t        ld_q[$];
    int          streak;
    logic        m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [1:0] lo,
                                            input logic [31:0] d);
`ifdef WB_LOAD_EXT_EN
        logic [31:0] s;
        s = d >> (8 * lo);
        case (f3)
            3'b000:  return (s[7]  ? 32'hFFFF_FF00 : 32'h0) | (s & 32'h0000_00FF);
            3'b001:  return (s[15] ? 32'hFFFF_0000 : 32'h0) | (s & 32'h0000_FFFF);
            3'b100:  return s & 32'h0000_00FF;
            3'b101:  return s & 32'h0000_FFFF;
            default: return d;
        endcase
`else
        if (f3 == 3'b111 && lo == 2'b11) return d;
        return d;
`endif
    endfunction

    task automatic model_edge();
        int   old_alu;
        ent_t w;
        bit   have;
        have = 1'b0;
        if (rst) begin
            alu_q.delete();
            ld_q.delete();
            streak  = 0;
            m_wen   = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
            return;
        end
        old_alu = alu_q.size();
        if (ex_valid && old_alu < DEPTH) alu_q.push_back('{a: ex_waddr, d: ex_wdata});
        if (mem_valid && ld_q.size() == 0)
            ld_q.push_back('{a: mem_waddr, d: ref_ext(mem_funct3, mem_addr_lo, mem_rdata)});
        if (ld_q.size() > 0 && !(streak >= 3 && old_alu > 0)) begin
            w      = ld_q.pop_front();
            have   = 1'b1;
            streak = (old_alu > 0) ? streak + 1 : 0;
        end else if (alu_q.size() > 0) begin
            w      = alu_q.pop_front();
            have   = 1'b1;
            streak = 0;
        end
        m_wen   = have && (w.a != 5'd0);
        m_waddr = m_wen ? w.a : 5'd0;
        m_wdata = m_wen ? w.d : 32'd0;
    endtask

    function automatic logic [40:0] dut_out();
        return {reg_wen, reg_waddr, reg_wdata, busy, ex_ready, mem_ready};
    endfunction

    function automatic logic [40:0] model_out();
        logic b;
        b = (alu_q.size() > 0) || (ld_q.size() > 0) || m_wen;
        return {m_wen, m_waddr, m_wdata, b, !rst && (alu_q.size() < DEPTH), !rst && (ld_q.size() == 0)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit ev, input logic [4:0] ea, input logic [31:0] ed,
                         input bit mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic [2:0] f3, input logic [1:0] lo);
        ex_valid    = ev;
        ex_waddr    = ea;
        ex_wdata    = ed;
        mem_valid   = mv;
        mem_waddr   = ma;
        mem_rdata   = md;
        mem_funct3  = f3;
        mem_addr_lo = lo;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, F3_LW, 2'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        tick();
        chk({tag, "_in_reset"}, {reg_wen, reg_waddr, reg_wdata, busy, ex_ready, mem_ready}, 41'd0);
        rst = 1'b0;
        idle();
        #1;
        chk({tag, "_after_reset"}, {reg_wen, busy, ex_ready, mem_ready}, 4'b0011);
    endtask

    typedef struct {
        bit          ev;
        logic [4:0]  ea;
        logic [31:0] ed;
        bit          mv;
        logic [4:0]  ma;
        logic [31:0] md;
        bit          wen;
        logic [4:0]  wa;
        logic [31:0] wd;
        bit          bsy;
        bit          exr;
        bit          memr;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [2:0] f3_set[5];
        logic [4:0] exp_a;
        logic [31:0] exp_d;
        bit exp_exr;
        f3_set = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};

        rst = 1'b1;
        idle();
        do_reset("init");

        // Latency, same-cycle contention, x0 suppression.
        tbl[0] = '{1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 32'h0,           1'b1, 5'd5, 32'h0000_1234, 1'b1, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,           1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 5'd7, 32'h0000_0001, 1'b1, 5'd6, 32'hAAAA_5555,   1'b1, 5'd6, 32'hAAAA_5555, 1'b1, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,           1'b1, 5'd7, 32'h0000_0001, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0,           1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,           1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].ev, tbl[i].ea, tbl[i].ed, tbl[i].mv, tbl[i].ma, tbl[i].md, F3_LW, 2'd0);
            tick();
            chk($sformatf("vec%0d", i), dut_out(),
                {tbl[i].wen, tbl[i].wa, tbl[i].wd, tbl[i].bsy, tbl[i].exr, tbl[i].memr});
        end

        // Loads every cycle, two ALU results queued: ALU head wins after 3 starved load writes.
        idle();
        for (int c = 0; c < 5; c++) begin
            if (c == 0)      drive(1'b1, 5'd9,  32'h9,  1'b1, 5'(11 + c), 32'h100 + c, F3_LW, 2'd0);
            else if (c == 1) drive(1'b1, 5'd10, 32'hA,  1'b1, 5'(11 + c), 32'h100 + c, F3_LW, 2'd0);
            else             drive(1'b1, 5'd20, 32'h20, 1'b1, 5'(11 + c), 32'h100 + c, F3_LW, 2'd0);
            tick();
            exp_a   = (c < 4) ? 5'(11 + c) : 5'd9;
            exp_d   = (c < 4) ? 32'h100 + c : 32'h9;
            exp_exr = (c == 0 || c == 4);
            chk($sformatf("starve%0d", c), {reg_wen, reg_waddr, reg_wdata, ex_ready, mem_ready},
                {1'b1, exp_a, exp_d, exp_exr, (c != 4)});
        end

        // Reset with queued ALU result and a held load; valids stay asserted through reset.
        do_reset("midop");
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("post_rst%0d", c), {reg_wen, reg_waddr, reg_wdata, busy, ex_ready, mem_ready},
                {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1});
        end

        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h80FF_FFFF, F3_LB, 2'd3);
        tick();
`ifdef WB_LOAD_EXT_EN
        chk("ext_lb", {reg_wen, reg_waddr, reg_wdata}, {1'b1, 5'd12, 32'hFFFF_FF80});
`else
        chk("raw_lb", {reg_wen, reg_waddr, reg_wdata}, {1'b1, 5'd12, 32'h80FF_FFFF});
`endif
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'h8001_0000, F3_LHU, 2'd2);
        tick();
`ifdef WB_LOAD_EXT_EN
        chk("ext_lhu", {reg_wen, reg_waddr, reg_wdata}, {1'b1, 5'd13, 32'h0000_8001});
`else
        chk("raw_lhu", {reg_wen, reg_waddr, reg_wdata}, {1'b1, 5'd13, 32'h8001_0000});
`endif
        idle();

        do_reset("rand");
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 1) == 1,
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  $urandom(),
                  $urandom_range(0, 9) < 4,
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  $urandom(),
                  f3_set[$urandom_range(0, 4)],
                  2'($urandom_range(0, 3)));
            tick();
            chk($sformatf("rand%0d", c), dut_out(), model_out());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
